// File: rtl/opc5ls_intc.sv
// Memory-mapped interrupt controller for the OPC5LS CPU: synchronises NSRC
// request lines, latches them as edge or level pending bits and drives int_b.
module opc5ls_intc #(
    parameter logic [15:0] BASE = 16'hFE00,
    parameter int          NSRC = 8
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic [15:0]     address,
    input  logic [15:0]     wdata,
    input  logic            rnw,
    input  logic [NSRC-1:0] irq,
    output logic [15:0]     rdata,
    output logic            sel,
    output logic            int_b
);

    logic [NSRC-1:0] r_s1;
    logic [NSRC-1:0] r_s2;
    logic [NSRC-1:0] r_s3;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_enable;
    logic [NSRC-1:0] r_edge;
    logic            r_int_b;

    logic            w_wr;
    logic [2:0]      w_off;
    logic [NSRC-1:0] w_wbits;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_active;
    logic [15:0]     w_vector;
    logic            w_unused;

    assign sel     = (address[15:3] == BASE[15:3]);
    assign w_off   = address[2:0];
    assign w_wr    = sel & ~rnw;
    assign w_wbits = wdata[NSRC-1:0];
    assign w_clr   = (w_wr && w_off == 3'd2) ? w_wbits : '0;
    assign w_set   = (w_wr && w_off == 3'd5) ? w_wbits : '0;
    assign w_rise  = r_s2 & ~r_s3;

    // Edge sources hold until cleared (a same-cycle edge or SET wins);
    // level sources simply follow the synchronised request.
    assign w_pend_nxt = (r_edge & (w_rise | w_set | (r_pend & ~w_clr)))
                      | (~r_edge & r_s2);
    assign w_active   = r_pend & r_enable;
    assign int_b      = r_int_b;
    assign w_unused   = &{1'b0, wdata};

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= irq;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_pend   <= '0;
            r_enable <= '0;
            r_edge   <= '0;
            r_int_b  <= 1'b1;
        end else begin
            r_pend  <= w_pend_nxt;
            r_int_b <= ~(|w_active);
            if (w_wr && w_off == 3'd1) begin
                r_enable <= w_wbits;
            end
            if (w_wr && w_off == 3'd3) begin
                r_edge <= w_wbits;
            end
        end
    end

    // Lowest-numbered active source wins; bit 15 flags "nothing pending".
    always_comb begin
        w_vector = 16'h8000;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vector = {12'h000, i[3:0]};
            end
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (sel) begin
            case (w_off)
                3'd0:    rdata = 16'(r_pend);
                3'd1:    rdata = 16'(r_enable);
                3'd3:    rdata = 16'(r_edge);
                3'd4:    rdata = w_vector;
                default: rdata = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_opc5ls_intc.sv
// Bench for opc5ls_intc: a history-based model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_opc5ls_intc;

    localparam logic [15:0] BASE = 16'hFE00;
    localparam int          NSRC = 8;

    logic            clk     = 1'b0;
    logic            reset_b = 1'b0;
    logic [15:0]     address = 16'h0000;
    logic [15:0]     wdata   = 16'h0000;
    logic            rnw     = 1'b1;
    logic [NSRC-1:0] irq     = '0;
    logic [15:0]     rdata;
    logic            sel;
    logic            int_b;

    int errors = 0;
    int checks = 0;

    opc5ls_intc #(.BASE(BASE), .NSRC(NSRC)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .address (address),
        .wdata   (wdata),
        .rnw     (rnw),
        .irq     (irq),
        .rdata   (rdata),
        .sel     (sel),
        .int_b   (int_b)
    );

    always #10 clk = ~clk;

    // Model state: irq as sampled at each clock edge, indexed by edge number.
    logic [NSRC-1:0] hist [0:4095];
    logic [NSRC-1:0] mPend, mEn, mEdge;
    logic            mIntB;
    int              cyc    = 0;
    int              rstCyc = 0;
    logic [NSRC-1:0] mS2, mS3, mRise, mClr, mSet, mNext;
    logic            mWr;

    function automatic logic [NSRC-1:0] past(input int idx);
        if (idx < rstCyc || idx < 0) return '0;
        return hist[idx];
    endfunction

    function automatic logic [15:0] modelRead(input logic [15:0] a);
        logic [NSRC-1:0] act;
        if (a[15:3] != BASE[15:3]) return 16'h0000;
        case (a[2:0])
            3'd0: return 16'(mPend);
            3'd1: return 16'(mEn);
            3'd3: return 16'(mEdge);
            3'd4: begin
                act = mPend & mEn;
                for (int i = 0; i < NSRC; i++) begin
                    if (act[i]) return 16'(i);
                end
                return 16'h8000;
            end
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mPend  = '0;
            mEn    = '0;
            mEdge  = '0;
            mIntB  = 1'b1;
            rstCyc = cyc;
        end else begin
            mS2   = past(cyc - 2);
            mS3   = past(cyc - 3);
            mRise = mS2 & ~mS3;
            mWr   = (address[15:3] == BASE[15:3]) && !rnw;
            mClr  = (mWr && address[2:0] == 3'd2) ? wdata[NSRC-1:0] : '0;
            mSet  = (mWr && address[2:0] == 3'd5) ? wdata[NSRC-1:0] : '0;
            for (int i = 0; i < NSRC; i++) begin
                mNext[i] = mEdge[i] ? (mRise[i] | mSet[i] | (mPend[i] & ~mClr[i])) : mS2[i];
            end
            mIntB = ~(|(mPend & mEn));
            mPend = mNext;
            if (mWr && address[2:0] == 3'd1) mEn = wdata[NSRC-1:0];
            if (mWr && address[2:0] == 3'd3) mEdge = wdata[NSRC-1:0];
            if (cyc < 4096) hist[cyc] = irq;
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset_b) begin
            checkOutput("cyc_int_b", {15'h0, int_b}, {15'h0, mIntB});
            checkOutput("cyc_rdata", rdata, modelRead(address));
            checkOutput("cyc_sel", {15'h0, sel}, {15'h0, address[15:3] == BASE[15:3]});
        end
    end

    task automatic applyStimulus(input logic [2:0] off, input logic [15:0] data);
        @(negedge clk);
        address = BASE + {13'h0, off};
        wdata   = data;
        rnw     = 1'b0;
        @(negedge clk);
        rnw     = 1'b1;
        address = BASE;
    endtask

    task automatic readCheck(input logic [2:0] off, input logic [15:0] exp, input string name);
        address = BASE + {13'h0, off};
        #1;
        checkOutput(name, rdata, exp);
    endtask

    task automatic intCheck(input logic exp, input string name);
        checkOutput(name, {15'h0, int_b}, {15'h0, exp});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        intCheck(1'b1, "int_b_in_reset");
        reset_b = 1'b1;
        @(negedge clk);
        for (int o = 0; o < 8; o++) begin
            readCheck(3'(o), (o == 4) ? 16'h8000 : 16'h0000, "reset_regs");
        end
        @(negedge clk);
        address = 16'hFDFF; #1;
        checkOutput("sel_below", {15'h0, sel}, 16'h0000);
        checkOutput("rdata_below", rdata, 16'h0000);
        address = 16'hFE08; #1;
        checkOutput("sel_above", {15'h0, sel}, 16'h0000);
        checkOutput("rdata_above", rdata, 16'h0000);
        address = 16'hFE07; #1;
        checkOutput("sel_top", {15'h0, sel}, 16'h0001);
        address = 16'hFE00; #1;
        checkOutput("sel_base", {15'h0, sel}, 16'h0001);
        intCheck(1'b1, "int_b_after_reset");

        // Edge source 2: one-cycle pulse, then clear.
        applyStimulus(3'd3, 16'h0004);
        applyStimulus(3'd1, 16'h0004);
        irq[2] = 1'b1;
        @(negedge clk); irq[2] = 1'b0;
        repeat (2) @(negedge clk);
        readCheck(3'd0, 16'h0004, "edge_pend_e3");
        intCheck(1'b1, "edge_int_b_e3");
        @(negedge clk);
        intCheck(1'b0, "edge_int_b_e4");
        readCheck(3'd4, 16'h0002, "edge_vector");
        applyStimulus(3'd2, 16'h0004);
        readCheck(3'd0, 16'h0000, "edge_cleared");
        intCheck(1'b0, "edge_int_b_ec");
        @(negedge clk);
        intCheck(1'b1, "edge_int_b_ec1");

        // Level source 5: CLEAR has no effect, follows irq.
        applyStimulus(3'd1, 16'h0020);
        irq[5] = 1'b1;
        repeat (4) @(negedge clk);
        readCheck(3'd0, 16'h0020, "level_pend");
        intCheck(1'b0, "level_int_b");
        applyStimulus(3'd2, 16'h0020);
        readCheck(3'd0, 16'h0020, "level_clear_ignored");
        intCheck(1'b0, "level_int_b_held");
        irq[5] = 1'b0;
        repeat (2) @(negedge clk);
        readCheck(3'd0, 16'h0020, "level_pend_e2");
        @(negedge clk);
        readCheck(3'd0, 16'h0000, "level_pend_e3");
        intCheck(1'b0, "level_int_b_e3");
        @(negedge clk);
        intCheck(1'b1, "level_int_b_e4");

        // Vector priority with edge sources 1 and 6.
        applyStimulus(3'd3, 16'h0046);
        applyStimulus(3'd1, 16'h0000);
        irq = 8'h42;
        @(negedge clk); irq = 8'h00;
        repeat (2) @(negedge clk);
        readCheck(3'd0, 16'h0042, "prio_pend");
        readCheck(3'd4, 16'h8000, "prio_vec_none");
        applyStimulus(3'd1, 16'h0040);
        readCheck(3'd4, 16'h0006, "prio_vec6");
        applyStimulus(3'd1, 16'h0042);
        readCheck(3'd4, 16'h0001, "prio_vec1");
        applyStimulus(3'd2, 16'h0042);
        readCheck(3'd0, 16'h0000, "prio_cleared");

        // Edge source 3: new edge lands on the same cycle as its CLEAR.
        applyStimulus(3'd3, 16'h004E);
        irq[3] = 1'b1;
        @(negedge clk); irq[3] = 1'b0;
        repeat (2) @(negedge clk);
        readCheck(3'd0, 16'h0008, "race_first_pend");
        irq[3] = 1'b1;
        @(negedge clk); irq[3] = 1'b0;
        @(negedge clk);
        address = BASE + 16'd2;
        wdata   = 16'h0008;
        rnw     = 1'b0;
        @(negedge clk);
        rnw     = 1'b1;
        readCheck(3'd0, 16'h0008, "race_set_wins");
        applyStimulus(3'd2, 16'h0008);
        readCheck(3'd0, 16'h0000, "race_cleared");

        // Software SET on edge source 0, unused-bit masking, reserved writes.
        applyStimulus(3'd3, 16'h004F);
        applyStimulus(3'd5, 16'h0001);
        readCheck(3'd0, 16'h0001, "swset_pend");
        readCheck(3'd5, 16'h0000, "set_reads0");
        readCheck(3'd2, 16'h0000, "clear_reads0");
        applyStimulus(3'd6, 16'hFFFF);
        readCheck(3'd6, 16'h0000, "reserved6");
        readCheck(3'd7, 16'h0000, "reserved7");
        applyStimulus(3'd1, 16'hFFFF);
        readCheck(3'd1, 16'h00FF, "enable_mask");
        @(negedge clk);
        intCheck(1'b0, "swset_int_b");

        // Asynchronous reset in the middle of an active interrupt.
        #3;
        reset_b = 1'b0;
        #1;
        intCheck(1'b1, "async_int_b");
        readCheck(3'd0, 16'h0000, "async_pend");
        readCheck(3'd1, 16'h0000, "async_enable");
        readCheck(3'd3, 16'h0000, "async_edge");
        readCheck(3'd4, 16'h8000, "async_vector");
        irq[7] = 1'b1;
        @(negedge clk);
        reset_b = 1'b1;
        address = BASE;
        repeat (4) @(negedge clk);
        readCheck(3'd0, 16'h0080, "repend_level");
        applyStimulus(3'd3, 16'h0080);
        readCheck(3'd0, 16'h0080, "type_change_kept");
        applyStimulus(3'd1, 16'h0080);
        @(negedge clk);
        intCheck(1'b0, "repend_int_b");
        applyStimulus(3'd2, 16'h0080);
        readCheck(3'd0, 16'h0000, "repend_cleared");
        irq = '0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
